// File: rtl/hex_display_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_display_scheduler: pages DATA/COUNT/STATUS onto four active-low HEX     |
// | digits, selected by button, auto-advance timer or forced by LOCKUP.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hex_display_scheduler #(
  parameter int PAGE_TICKS = 50_000_000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [15:0] DataOut,
  input  logic        DataValid,
  input  logic        LOCKUP,
  input  logic        Running,
  input  logic        PageBtn,
  input  logic        AutoMode,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [1:0]  Page
);

  localparam int TIMER_W = (PAGE_TICKS > 2) ? $clog2(PAGE_TICKS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PAGE_TICKS - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    PG_DATA   = 2'd0,
    PG_COUNT  = 2'd1,
    PG_STATUS = 2'd2
  } page_e;

  page_e               page_q, page_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [15:0]         latch_q, latch_d;
  logic [15:0]         count_q, count_d;
  logic                seen_q, seen_d;
  logic                btn_sync1_q, btn_sync1_d;
  logic                btn_sync2_q, btn_sync2_d;
  logic                btn_sync3_q, btn_sync3_d;
  logic [3:0][6:0]     hex_q, hex_d;
  logic                btn_pulse;
  logic                timer_expired;
  logic                advance;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Button path: two-flop synchroniser, third flop for rising-edge detect.
  always_comb begin
    btn_sync1_d   = PageBtn;
    btn_sync2_d   = btn_sync1_q;
    btn_sync3_d   = btn_sync2_q;
    btn_pulse     = btn_sync2_q & ~btn_sync3_q;
    timer_expired = AutoMode && (timer_q == TIMER_LAST);
    advance       = btn_pulse || timer_expired;

    page_d = page_q;
    if (LOCKUP) begin
      page_d = PG_STATUS;
    end else if (advance) begin
      case (page_q)
        PG_DATA:  page_d = PG_COUNT;
        PG_COUNT: page_d = PG_STATUS;
        default:  page_d = PG_DATA;
      endcase
    end

    timer_d = timer_q;
    if (!AutoMode || (page_d != page_q)) begin
      timer_d = '0;
    end else if (!LOCKUP) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    latch_d = DataValid ? DataOut : latch_q;
    count_d = DataValid ? (count_q + 16'd1) : count_q;
    seen_d  = seen_q | DataValid;
  end

  // Display is built from the registered page/data, so it lags them by one cycle.
  always_comb begin
    hex_d = {4{SEG_BLANK}};
    case (page_q)
      PG_DATA: begin
        hex_d[3] = hex_glyph(latch_q[15:12]);
        hex_d[2] = hex_glyph(latch_q[11:8]);
        hex_d[1] = hex_glyph(latch_q[7:4]);
        hex_d[0] = hex_glyph(latch_q[3:0]);
      end
      PG_COUNT: begin
        hex_d[3] = hex_glyph(count_q[15:12]);
        hex_d[2] = hex_glyph(count_q[11:8]);
        hex_d[1] = hex_glyph(count_q[7:4]);
        hex_d[0] = hex_glyph(count_q[3:0]);
      end
      PG_STATUS: begin
        hex_d[3] = LOCKUP  ? SEG_L : SEG_BLANK;
        hex_d[2] = Running ? SEG_R : SEG_BLANK;
        hex_d[1] = seen_q  ? SEG_D : SEG_BLANK;
        hex_d[0] = SEG_DASH;
      end
      default: hex_d = {4{SEG_BLANK}};
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      page_q      <= PG_DATA;
      timer_q     <= '0;
      latch_q     <= '0;
      count_q     <= '0;
      seen_q      <= 1'b0;
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      btn_sync3_q <= 1'b0;
      hex_q       <= {4{SEG_BLANK}};
    end else begin
      page_q      <= page_d;
      timer_q     <= timer_d;
      latch_q     <= latch_d;
      count_q     <= count_d;
      seen_q      <= seen_d;
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      btn_sync3_q <= btn_sync3_d;
      hex_q       <= hex_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign Page = page_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hex_display_scheduler: randomized bench with a behavioural page model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hex_display_scheduler;

  localparam int PT = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_out = '0;
  logic        data_valid = 1'b0;
  logic        lockup = 1'b0;
  logic        running = 1'b0;
  logic        page_btn = 1'b0;
  logic        auto_mode = 1'b0;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [1:0]  page;

  hex_display_scheduler #(.PAGE_TICKS(PT)) dut (
    .HCLK(clk), .HRESETn(rst_n), .DataOut(data_out), .DataValid(data_valid),
    .LOCKUP(lockup), .Running(running), .PageBtn(page_btn), .AutoMode(auto_mode),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .Page(page)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: page index mod 3, button seen through a history of samples.
  int         m_page, m_timer, m_count, m_latch, np;
  bit         m_seen, pulse, expiry;
  bit         bh1, bh2, bh3;
  logic [6:0] e3, e2, e1, e0;
  logic [29:0] exp_all, dut_all;

  assign dut_all = {hex3, hex2, hex1, hex0, page};
  assign exp_all = {e3, e2, e1, e0, m_page[1:0]};

  function automatic logic [6:0] glyph(input int v);
    return GLYPH[v & 15];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_page = 0; m_timer = 0; m_count = 0; m_latch = 0; m_seen = 0;
      bh1 = 0; bh2 = 0; bh3 = 0;
      e3 = 7'h7F; e2 = 7'h7F; e1 = 7'h7F; e0 = 7'h7F;
    end else begin
      if (m_page == 0) begin
        e3 = glyph(m_latch >> 12); e2 = glyph(m_latch >> 8); e1 = glyph(m_latch >> 4); e0 = glyph(m_latch);
      end else if (m_page == 1) begin
        e3 = glyph(m_count >> 12); e2 = glyph(m_count >> 8); e1 = glyph(m_count >> 4); e0 = glyph(m_count);
      end else begin
        e3 = lockup ? 7'h47 : 7'h7F;
        e2 = running ? 7'h2F : 7'h7F;
        e1 = m_seen ? 7'h21 : 7'h7F;
        e0 = 7'h3F;
      end
      pulse  = bh2 && !bh3;
      expiry = auto_mode && (m_timer == PT - 1);
      if (lockup) np = 2;
      else if (pulse || expiry) np = (m_page + 1) % 3;
      else np = m_page;
      if (!auto_mode || np != m_page) m_timer = 0;
      else if (!lockup) m_timer = m_timer + 1;
      m_page = np;
      if (data_valid) begin
        m_latch = data_out;
        m_count = (m_count + 1) % 65536;
        m_seen  = 1;
      end
      bh3 = bh2; bh2 = bh1; bh1 = page_btn;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_all !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0}) begin
      failures++; $display("FAIL reset_state: got %h expected %h", dut_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_all !== {7'h40, 7'h40, 7'h40, 7'h40, 2'd0}) begin
      failures++; $display("FAIL reset_release: got %h expected %h", dut_all, {7'h40, 7'h40, 7'h40, 7'h40, 2'd0});
    end
  endtask

  task automatic test_capture();
    data_out = 16'h1234; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_all !== {7'h79, 7'h24, 7'h30, 7'h19, 2'd0}) begin
      failures++; $display("FAIL capture_1234: got %h expected %h", dut_all, {7'h79, 7'h24, 7'h30, 7'h19, 2'd0});
    end
    for (int i = 0; i < 30; i++) begin
      data_out = 16'($urandom); data_valid = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checks++;
      if (dut_all !== exp_all) begin
        failures++; $display("FAIL capture_rand: got %h expected %h", dut_all, exp_all);
      end
    end
    data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_button();
    for (int p = 0; p < 3; p++) begin
      page_btn = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (i == 10) page_btn = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_all !== exp_all) begin
          failures++; $display("FAIL button_model: got %h expected %h", dut_all, exp_all);
        end
      end
      checks++;
      if (page !== 2'((p + 1) % 3)) begin
        failures++; $display("FAIL button_step: got %0d expected %0d", page, (p + 1) % 3);
      end
    end
    page_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) page_btn = 1'b0;
      data_valid = (i >= 12 && i < 15);
      data_out = 16'($urandom);
      @(negedge clk);
      checks++;
      if (dut_all !== exp_all) begin
        failures++; $display("FAIL button_count_page: got %h expected %h", dut_all, exp_all);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_auto();
    int changes = 0;
    logic [1:0] prev;
    int pb;
    bit found = 0;
    prev = page;
    auto_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (dut_all !== exp_all) begin
        failures++; $display("FAIL auto_model: got %h expected %h", dut_all, exp_all);
      end
      if (page !== prev) changes++;
      prev = page;
    end
    checks++;
    if (changes != 6) begin
      failures++; $display("FAIL auto_rate: got %0d changes expected 6", changes);
    end
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_timer == 1 && !bh1 && !bh2 && !bh3) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL auto_align: timer alignment not reached, got %0d expected 1", m_timer);
    end
    pb = m_page;
    page_btn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (page !== 2'((pb + 1) % 3)) begin
      failures++; $display("FAIL coincide_single: got %0d expected %0d", page, (pb + 1) % 3);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (page !== 2'((pb + 1) % 3)) begin
      failures++; $display("FAIL coincide_restart_hold: got %0d expected %0d", page, (pb + 1) % 3);
    end
    @(negedge clk);
    checks++;
    if (page !== 2'((pb + 2) % 3)) begin
      failures++; $display("FAIL coincide_restart_next: got %0d expected %0d", page, (pb + 2) % 3);
    end
    page_btn = 1'b0;
    for (int off = 0; off < 4; off++) begin
      for (int i = 0; i < 10 + off; i++) begin
        page_btn = (i < 6);
        @(negedge clk);
        checks++;
        if (dut_all !== exp_all) begin
          failures++; $display("FAIL auto_btn_mix: got %h expected %h", dut_all, exp_all);
        end
      end
    end
    auto_mode = 1'b0;
    page_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lockup();
    for (int n = 0; n < 3 && m_page != 0; n++) begin
      page_btn = 1'b1;
      repeat (10) @(negedge clk);
      page_btn = 1'b0;
      repeat (6) @(negedge clk);
    end
    running = 1'b1; lockup = 1'b1; auto_mode = 1'b1;
    @(negedge clk);
    checks++;
    if (page !== 2'd2) begin
      failures++; $display("FAIL lockup_force: got %0d expected 2", page);
    end
    @(negedge clk);
    checks++;
    if (hex3 !== 7'h47) begin
      failures++; $display("FAIL lockup_glyph: got %h expected 47", hex3);
    end
    for (int i = 0; i < 14; i++) begin
      page_btn = (i < 8);
      @(negedge clk);
      checks++;
      if (dut_all !== exp_all || page !== 2'd2) begin
        failures++; $display("FAIL lockup_hold: got %h expected %h", dut_all, exp_all);
      end
    end
    lockup = 1'b0; auto_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (hex3 !== 7'h7F || page !== 2'd2) begin
      failures++; $display("FAIL lockup_release: got hex3=%h page=%0d expected hex3=7f page=2", hex3, page);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      data_out   = 16'($urandom);
      data_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) page_btn = ~page_btn;
      if ($urandom_range(0, 40) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 30) == 0) lockup = ~lockup;
      if ($urandom_range(0, 50) == 0) running = ~running;
      @(negedge clk);
      checks++;
      if (dut_all !== exp_all) begin
        failures++; $display("FAIL random_model: got %h expected %h", dut_all, exp_all);
      end
    end
    data_valid = 1'b0; page_btn = 1'b0; auto_mode = 1'b0; lockup = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    n = (m_count == 0) ? 65536 : 65536 - m_count;
    data_valid = 1'b1;
    repeat (n) begin
      data_out = 16'($urandom);
      @(negedge clk);
    end
    data_valid = 1'b0;
    for (int k = 0; k < 3 && m_page != 1; k++) begin
      page_btn = 1'b1;
      repeat (10) @(negedge clk);
      page_btn = 1'b0;
      repeat (6) @(negedge clk);
    end
    checks++;
    if (dut_all !== {7'h40, 7'h40, 7'h40, 7'h40, 2'd1}) begin
      failures++; $display("FAIL count_wrap: got %h expected %h", dut_all, {7'h40, 7'h40, 7'h40, 7'h40, 2'd1});
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    auto_mode = 1'b1;
    data_valid = 1'b1; data_out = 16'hBEEF;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checks++;
      if (dut_all !== exp_all) begin
        failures++; $display("FAIL reset_mid_model: got %h expected %h", dut_all, exp_all);
      end
      if (page === 2'd1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_mid_reach: got page %0d expected 1", page);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_all !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0}) begin
      failures++; $display("FAIL reset_async: got %h expected %h", dut_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0});
    end
    @(negedge clk);
    rst_n = 1'b1; auto_mode = 1'b0; running = 1'b1; lockup = 1'b0;
    for (int k = 0; k < 2; k++) begin
      page_btn = 1'b1;
      repeat (10) @(negedge clk);
      page_btn = 1'b0;
      repeat (6) @(negedge clk);
    end
    checks++;
    if (dut_all !== {7'h7F, 7'h2F, 7'h7F, 7'h3F, 2'd2}) begin
      failures++; $display("FAIL reset_seen_clear: got %h expected %h", dut_all, {7'h7F, 7'h2F, 7'h7F, 7'h3F, 2'd2});
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_button();
    test_auto();
    test_lockup();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
